// File: rtl/instr_fetch_decode_if.sv
// ============================================================================
// Module : instr_fetch_decode_if
// Brief  : PC, instruction-memory and execute-stage bundle for the fetch/decode
//          sequencer. Optional retired_cnt present under IFD_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_fetch_decode_if #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 16,
  parameter int OP_W    = 4
);
  logic               run;
  logic [ADDR_W-1:0]  pc_addr;
  logic               pc_advance;
  logic               cond_jump;
  logic               uncond_jump;
  logic [ADDR_W-1:0]  jump_data;
  logic               stop;
  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               zero_flag;
  logic               ex_valid;
  logic               ex_ready;
  logic [OP_W-1:0]    ex_op;
  logic [ADDR_W-1:0]  ex_imm;
  logic               illegal;

`ifdef IFD_PERF_CNT_EN
  logic [15:0]        retired_cnt;

  modport master (
    input  run, pc_addr, imem_data, zero_flag, ex_ready,
    output pc_advance, cond_jump, uncond_jump, jump_data, stop,
           imem_en, imem_addr, ex_valid, ex_op, ex_imm, illegal, retired_cnt
  );
  modport slave (
    output run, pc_addr, imem_data, zero_flag, ex_ready,
    input  pc_advance, cond_jump, uncond_jump, jump_data, stop,
           imem_en, imem_addr, ex_valid, ex_op, ex_imm, illegal, retired_cnt
  );
`else
  modport master (
    input  run, pc_addr, imem_data, zero_flag, ex_ready,
    output pc_advance, cond_jump, uncond_jump, jump_data, stop,
           imem_en, imem_addr, ex_valid, ex_op, ex_imm, illegal
  );
  modport slave (
    output run, pc_addr, imem_data, zero_flag, ex_ready,
    input  pc_advance, cond_jump, uncond_jump, jump_data, stop,
           imem_en, imem_addr, ex_valid, ex_op, ex_imm, illegal
  );
`endif
endinterface

`default_nettype wire

// File: rtl/instr_fetch_decode.sv
// ============================================================================
// Module : instr_fetch_decode
// Brief  : Fetch/decode sequencer: fetches from sync imem, decodes, pulses the
//          PC, issues ALU ops. IFD_PERF_CNT_EN adds a retired-instruction count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_decode #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 16,
  parameter int OP_W    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_fetch_decode_if.master   ifd
);

  localparam logic [OP_W-1:0] OP_ALU_LO  = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_ALU_HI  = OP_W'(4'h7);
  localparam logic [OP_W-1:0] OP_JMP     = OP_W'(4'h8);
  localparam logic [OP_W-1:0] OP_JZ      = OP_W'(4'h9);
  localparam logic [OP_W-1:0] OP_JNZ     = OP_W'(4'hA);
  localparam logic [OP_W-1:0] OP_ILL_LO  = OP_W'(4'hB);
  localparam logic [OP_W-1:0] OP_HALT    = OP_W'(4'hF);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    DECODE = 3'd3,
    ISSUE  = 3'd4,
    UPDATE = 3'd5,
    HALTED = 3'd6
  } state_t;

  state_t              state_q;
  logic [INSTR_W-1:0]  ir_q;
  logic                pc_advance_q, cond_jump_q, uncond_jump_q;
  logic [ADDR_W-1:0]   jump_data_q;
  logic                stop_q, imem_en_q, ex_valid_q, illegal_q;
  logic [OP_W-1:0]     ex_op_q;
  logic [ADDR_W-1:0]   ex_imm_q;

  logic [OP_W-1:0]     w_opcode;
  logic [ADDR_W-1:0]   w_imm;
  logic                w_taken;

  assign w_opcode = ir_q[INSTR_W-1 -: OP_W];
  assign w_imm    = ir_q[ADDR_W-1:0];
  assign w_taken  = ((w_opcode == OP_JZ)  &&  ifd.zero_flag) ||
                    ((w_opcode == OP_JNZ) && !ifd.zero_flag);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ir_q          <= '0;
      pc_advance_q  <= 1'b0;
      cond_jump_q   <= 1'b0;
      uncond_jump_q <= 1'b0;
      jump_data_q   <= '0;
      stop_q        <= 1'b0;
      imem_en_q     <= 1'b0;
      ex_valid_q    <= 1'b0;
      ex_op_q       <= '0;
      ex_imm_q      <= '0;
      illegal_q     <= 1'b0;
    end else begin
      // PC pulses and the fetch strobe are single-cycle unless re-armed below.
      pc_advance_q  <= 1'b0;
      cond_jump_q   <= 1'b0;
      uncond_jump_q <= 1'b0;
      jump_data_q   <= '0;
      imem_en_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ifd.run) begin
            state_q   <= FETCH;
            imem_en_q <= 1'b1;
          end
        end
        FETCH:  state_q <= WAIT;
        WAIT: begin
          ir_q    <= ifd.imem_data;
          state_q <= DECODE;
        end
        DECODE: begin
          if (w_opcode == OP_HALT) begin
            stop_q  <= 1'b1;
            state_q <= HALTED;
          end else if (w_opcode >= OP_ALU_LO && w_opcode <= OP_ALU_HI) begin
            ex_op_q    <= w_opcode;
            ex_imm_q   <= w_imm;
            ex_valid_q <= 1'b1;
            state_q    <= ISSUE;
          end else begin
            state_q <= UPDATE;
            if (w_opcode == OP_JMP) begin
              uncond_jump_q <= 1'b1;
              jump_data_q   <= w_imm;
            end else if (w_taken) begin
              cond_jump_q <= 1'b1;
              jump_data_q <= w_imm;
            end else begin
              pc_advance_q <= 1'b1;
              if (w_opcode >= OP_ILL_LO) illegal_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (ifd.ex_ready) begin
            ex_valid_q   <= 1'b0;
            pc_advance_q <= 1'b1;
            state_q      <= UPDATE;
          end
        end
        UPDATE: begin
          if (ifd.run) begin
            state_q   <= FETCH;
            imem_en_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        HALTED:  state_q <= HALTED;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ifd.pc_advance  = pc_advance_q;
  assign ifd.cond_jump   = cond_jump_q;
  assign ifd.uncond_jump = uncond_jump_q;
  assign ifd.jump_data   = jump_data_q;
  assign ifd.stop        = stop_q;
  assign ifd.imem_en     = imem_en_q;
  // Address follows pc_addr live during FETCH so a PC update on the edge
  // ending UPDATE is what the memory sees; it is gated to 0 elsewhere.
  assign ifd.imem_addr   = imem_en_q ? ifd.pc_addr : '0;
  assign ifd.ex_valid    = ex_valid_q;
  assign ifd.ex_op       = ex_op_q;
  assign ifd.ex_imm      = ex_imm_q;
  assign ifd.illegal     = illegal_q;

`ifdef IFD_PERF_CNT_EN
  logic [15:0] retired_q, retired_d;
  logic        w_retire;

  assign w_retire = (state_q == UPDATE) ||
                    ((state_q == DECODE) && (w_opcode == OP_HALT));

  always_comb begin
    retired_d = retired_q;
    if (w_retire && (retired_q != 16'hFFFF)) retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign ifd.retired_cnt = retired_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
// ============================================================================
// Module : tb_instr_fetch_decode
// Brief  : Self-checking bench for instr_fetch_decode (directed + random).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_decode;

  localparam int K_NONE = 0, K_ADV = 1, K_COND = 2, K_JMP = 3, K_MULTI = 4;

  typedef struct {
    int          fetch_en, fetch_addr, pulse_at_fetch, extra_en;
    int          kind, pulse_at, jdata, valid_at, valid_cnt, unstable;
    int          ex_op, ex_imm, stop_at, illegal;
  } obs_t;

  typedef struct {
    int kind, pulse_at, jdata, valid_at, valid_cnt, ex_op, ex_imm, stop_at;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [15:0] mem [0:4095];
  int checks = 0;
  int errors = 0;
  int pc_model;
  int ill_model;

  instr_fetch_decode_if #(.ADDR_W(12), .INSTR_W(16), .OP_W(4)) bus ();
  instr_fetch_decode #(.ADDR_W(12), .INSTR_W(16), .OP_W(4)) dut (
    .clk(clk), .reset(reset), .ifd(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.imem_en) bus.imem_data <= mem[bus.imem_addr];

  // Reference: outcome of one instruction, cycle offsets relative to FETCH.
  function automatic exp_t predict(input logic [15:0] word, input bit z, input int stall);
    exp_t e;
    int op, imm;
    op  = int'(word[15:12]);
    imm = int'(word[11:0]);
    e = '{default: 0};
    if (op == 15) e.stop_at = 3;
    else if (op >= 1 && op <= 7) begin
      e.valid_at = 3; e.valid_cnt = stall + 1; e.pulse_at = 4 + stall;
      e.kind = K_ADV; e.ex_op = op; e.ex_imm = imm;
    end else begin
      e.pulse_at = 3;
      if (op == 8) begin e.kind = K_JMP; e.jdata = imm; end
      else if ((op == 9 && z) || (op == 10 && !z)) begin e.kind = K_COND; e.jdata = imm; end
      else e.kind = K_ADV;
    end
    return e;
  endfunction

  // Starts at the negedge inside FETCH; returns at the pulse/stop negedge.
  task automatic run_instr(input logic [15:0] word, input bit z, input int stall, output obs_t o);
    int vcnt, np;
    o = '{default: 0};
    mem[bus.pc_addr] = word;
    o.fetch_en       = int'(bus.imem_en);
    o.fetch_addr     = int'(bus.imem_addr);
    o.pulse_at_fetch = int'(bus.pc_advance | bus.cond_jump | bus.uncond_jump);
    bus.zero_flag = z;
    bus.ex_ready  = (stall == 0);
    vcnt = 0;
    for (int k = 1; k <= 8 + stall; k++) begin
      @(negedge clk);
      if (bus.imem_en) o.extra_en++;
      if (bus.ex_valid) begin
        vcnt++;
        if (vcnt == 1) begin
          o.valid_at = k; o.ex_op = int'(bus.ex_op); o.ex_imm = int'(bus.ex_imm);
        end else if (int'(bus.ex_op) != o.ex_op || int'(bus.ex_imm) != o.ex_imm) o.unstable = 1;
        bus.ex_ready = (vcnt > stall);
      end
      np = int'(bus.pc_advance) + int'(bus.cond_jump) + int'(bus.uncond_jump);
      if (np != 0) begin
        o.pulse_at = k;
        o.jdata    = int'(bus.jump_data);
        o.kind     = (np > 1) ? K_MULTI : bus.pc_advance ? K_ADV : bus.cond_jump ? K_COND : K_JMP;
        if (bus.pc_advance)       bus.pc_addr = bus.pc_addr + 12'd1;
        else if (bus.cond_jump)   bus.pc_addr = bus.pc_addr + bus.jump_data;
        else                      bus.pc_addr = bus.jump_data;
        break;
      end
      if (bus.stop) begin o.stop_at = k; break; end
    end
    o.valid_cnt = vcnt;
    o.illegal   = int'(bus.illegal);
    bus.ex_ready = 1'b0;
  endtask

  task automatic start();
    reset = 1'b1; bus.run = 1'b0; bus.pc_addr = '0; bus.zero_flag = 1'b0; bus.ex_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; bus.run = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.run = 1'b1; bus.pc_addr = 12'h3C5; bus.zero_flag = 1'b1; bus.ex_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.pc_advance, bus.cond_jump, bus.uncond_jump, bus.jump_data, bus.stop, bus.imem_en,
         bus.imem_addr, bus.ex_valid, bus.ex_op, bus.ex_imm, bus.illegal} !== 47'd0) begin
      errors++; $display("FAIL reset_outputs: outputs not all zero under reset");
    end
`ifdef IFD_PERF_CNT_EN
    checks++;
    if (bus.retired_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_retired: got %0d want 0", bus.retired_cnt);
    end
`endif
  endtask

  task automatic test_alu_first();
    obs_t o;
    start();
    run_instr(16'h1005, 1'b0, 0, o);
    checks++; if (o.fetch_en != 1 || o.fetch_addr != 0) begin
      errors++; $display("FAIL alu_first_fetch: en=%0d addr=%h want en=1 addr=000", o.fetch_en, o.fetch_addr); end
    checks++; if (o.valid_at != 3 || o.ex_op != 1 || o.ex_imm != 5) begin
      errors++; $display("FAIL alu_first_issue: at=%0d op=%0d imm=%h want at=3 op=1 imm=005", o.valid_at, o.ex_op, o.ex_imm); end
    checks++; if (o.kind != K_ADV || o.pulse_at != 4) begin
      errors++; $display("FAIL alu_first_adv: kind=%0d at=%0d want kind=1 at=4", o.kind, o.pulse_at); end
  endtask

  task automatic test_jump();
    obs_t o;
    @(negedge clk);
    run_instr(16'h8123, 1'b0, 0, o);
    checks++; if (o.kind != K_JMP || o.jdata != 'h123 || o.pulse_at != 3) begin
      errors++; $display("FAIL jmp: kind=%0d data=%h at=%0d want kind=3 data=123 at=3", o.kind, o.jdata, o.pulse_at); end
    @(negedge clk);
    run_instr(16'h0000, 1'b0, 0, o);
    checks++; if (o.fetch_addr != 'h123 || o.pulse_at_fetch != 0 || o.fetch_en != 1) begin
      errors++; $display("FAIL jmp_next_fetch: addr=%h pulse=%0d en=%0d want addr=123 pulse=0 en=1",
                         o.fetch_addr, o.pulse_at_fetch, o.fetch_en); end
  endtask

  task automatic test_branch();
    obs_t o;
    @(negedge clk);
    run_instr(16'h9010, 1'b1, 0, o);
    checks++; if (o.kind != K_COND || o.jdata != 'h010) begin
      errors++; $display("FAIL jz_taken: kind=%0d data=%h want kind=2 data=010", o.kind, o.jdata); end
    @(negedge clk);
    run_instr(16'h9010, 1'b0, 0, o);
    checks++; if (o.kind != K_ADV) begin
      errors++; $display("FAIL jz_not_taken: kind=%0d want 1", o.kind); end
  endtask

  task automatic test_backpressure();
    obs_t o;
    @(negedge clk);
    run_instr(16'h3ABC, 1'b0, 3, o);
    checks++; if (o.valid_cnt != 4 || o.unstable != 0 || o.ex_op != 3 || o.ex_imm != 'hABC) begin
      errors++; $display("FAIL backpressure_hold: cnt=%0d unstable=%0d op=%0d imm=%h want 4 0 3 abc",
                         o.valid_cnt, o.unstable, o.ex_op, o.ex_imm); end
    checks++; if (o.kind != K_ADV || o.pulse_at != 7) begin
      errors++; $display("FAIL backpressure_adv: kind=%0d at=%0d want kind=1 at=7", o.kind, o.pulse_at); end
  endtask

  task automatic test_halt_illegal();
    obs_t o;
    int viol;
    @(negedge clk);
    run_instr(16'hC000, 1'b0, 0, o);
    checks++; if (o.illegal != 1 || o.kind != K_ADV) begin
      errors++; $display("FAIL illegal_op: illegal=%0d kind=%0d want 1 1", o.illegal, o.kind); end
    @(negedge clk);
    run_instr(16'hF000, 1'b0, 0, o);
    checks++; if (o.stop_at != 3 || o.kind != K_NONE) begin
      errors++; $display("FAIL halt_stop: at=%0d kind=%0d want at=3 kind=0", o.stop_at, o.kind); end
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.stop || bus.imem_en || bus.pc_advance || bus.cond_jump || bus.uncond_jump) viol++;
    end
    checks++; if (viol != 0) begin
      errors++; $display("FAIL halt_sticky: %0d bad cycles want 0", viol); end
    reset = 1'b1; bus.run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.stop !== 1'b0 || bus.illegal !== 1'b0 || bus.imem_en !== 1'b0) begin
      errors++; $display("FAIL halt_reset: stop=%b illegal=%b imem_en=%b want 0 0 0", bus.stop, bus.illegal, bus.imem_en); end
  endtask

  task automatic test_reset_in_issue();
    start();
    mem[0] = 16'h2001;
    bus.ex_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.ex_valid !== 1'b1) begin
      errors++; $display("FAIL issue_reached: ex_valid=%b want 1", bus.ex_valid); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.pc_advance, bus.cond_jump, bus.uncond_jump, bus.jump_data, bus.stop, bus.imem_en,
         bus.imem_addr, bus.ex_valid, bus.ex_op, bus.ex_imm, bus.illegal} !== 47'd0) begin
      errors++; $display("FAIL reset_in_issue: outputs not all zero, ex_valid=%b ex_op=%h", bus.ex_valid, bus.ex_op);
    end
    reset = 1'b0;
  endtask

`ifdef IFD_PERF_CNT_EN
  task automatic test_perf_cnt();
    obs_t o;
    start();
    run_instr(16'h0000, 1'b0, 0, o); @(negedge clk);
    run_instr(16'h4001, 1'b0, 1, o); @(negedge clk);
    run_instr(16'h8010, 1'b0, 0, o); @(negedge clk);
    run_instr(16'hF000, 1'b0, 0, o);
    repeat (3) @(negedge clk);
    checks++; if (bus.retired_cnt !== 16'd4) begin
      errors++; $display("FAIL perf_cnt: got %0d want 4", bus.retired_cnt); end
  endtask
`endif

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [15:0] word;
    bit z;
    int stall, op;
    start();
    pc_model = 0; ill_model = 0;
    for (int n = 0; n < 60; n++) begin
      op    = $urandom_range(0, 14);
      word  = {op[3:0], 12'($urandom)};
      z     = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3);
      e = predict(word, z, stall);
      if (op >= 11) ill_model = 1;
      run_instr(word, z, stall, o);
      checks++; if (o.fetch_en != 1 || o.fetch_addr != pc_model || o.pulse_at_fetch != 0 || o.extra_en != 0) begin
        errors++; $display("FAIL rnd_fetch[%0d]: en=%0d addr=%h pulse=%0d extra=%0d want 1 %h 0 0",
                           n, o.fetch_en, o.fetch_addr, o.pulse_at_fetch, o.extra_en, pc_model); end
      checks++; if (o.kind != e.kind || o.pulse_at != e.pulse_at) begin
        errors++; $display("FAIL rnd_pulse[%0d] word=%h: kind=%0d at=%0d want kind=%0d at=%0d",
                           n, word, o.kind, o.pulse_at, e.kind, e.pulse_at); end
      if (e.kind == K_JMP || e.kind == K_COND) begin
        checks++; if (o.jdata != e.jdata) begin
          errors++; $display("FAIL rnd_jdata[%0d]: got %h want %h", n, o.jdata, e.jdata); end
      end
      checks++; if (o.valid_cnt != e.valid_cnt || o.valid_at != e.valid_at || o.unstable != 0) begin
        errors++; $display("FAIL rnd_issue[%0d] word=%h: cnt=%0d at=%0d unstable=%0d want %0d %0d 0",
                           n, word, o.valid_cnt, o.valid_at, o.unstable, e.valid_cnt, e.valid_at); end
      if (e.valid_cnt != 0) begin
        checks++; if (o.ex_op != e.ex_op || o.ex_imm != e.ex_imm) begin
          errors++; $display("FAIL rnd_exdata[%0d]: op=%0d imm=%h want %0d %h", n, o.ex_op, o.ex_imm, e.ex_op, e.ex_imm); end
      end
      checks++; if (o.illegal != ill_model) begin
        errors++; $display("FAIL rnd_illegal[%0d]: got %0d want %0d", n, o.illegal, ill_model); end
      case (e.kind)
        K_ADV:   pc_model = (pc_model + 1) % 4096;
        K_COND:  pc_model = (pc_model + e.jdata) % 4096;
        default: pc_model = e.jdata;
      endcase
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    test_reset();
    test_alu_first();
    test_jump();
    test_branch();
    test_backpressure();
    test_halt_illegal();
    test_reset_in_issue();
`ifdef IFD_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
